cipher_avalon_ctrl: RTL

- Parametrised Avalon-MM slave that fronts a fixed-latency block-cipher core, e.g. the AES encryption core, with 128/192/256-bit keys.
- Address-mapped registers: plaintext, key, control, status and result.
- A latency-counter FSM replaces ad-hoc read/write counting.
- Sits between the Nios/Avalon fabric and the cipher core; exports done/irq to the system.

---
 rtl/cipher_avalon_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cipher_avalon_ctrl.sv
// Avalon-MM register front end for a fixed-latency block-cipher core.
// Optional CIPHER_AUTO_START_EN: a write to the last DIN word also starts a run.
module cipher_avalon_ctrl #(
  parameter int DATA_BITS    = 128,
  parameter int KEY_BITS     = 128,
  parameter int CORE_LATENCY = 35,
  parameter int ADDR_W       = 5
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 chipselect,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 read,
  input  logic                 write,
  input  logic [3:0]           byteenable,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [DATA_BITS-1:0] core_data_in,
  output logic [KEY_BITS-1:0]  core_key,
  output logic                 core_start,
  input  logic [DATA_BITS-1:0] core_data_out,
  output logic                 done_export,
  output logic                 irq
);
  localparam int DW = DATA_BITS / 32;
  localparam int KW = KEY_BITS / 32;
  localparam int CW = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0]   din  [DW];
  logic [31:0]   key  [KW];
  logic [31:0]   dout [DW];
  logic          irq_en, err;
  logic          go, cap;
  logic [31:0]   rd_mux;

  logic [1:0] region;
  logic [2:0] widx;
  logic       acc_wr, acc_rd, ctrl_wr, busy;
  logic       din_hit, key_hit, dout_hit, din_wr, key_wr;
  logic       start_ctrl, clr_req, auto_start, start_req;

  assign region     = address[4:3];
  assign widx       = address[2:0];
  assign acc_wr     = chipselect & write;
  assign acc_rd     = chipselect & read;
  assign busy       = (state == RUN);
  assign ctrl_wr    = acc_wr && (address == '0) && byteenable[0];
  assign din_hit    = (region == 2'b01) && (int'(widx) < DW);
  assign key_hit    = (region == 2'b10) && (int'(widx) < KW);
  assign dout_hit   = (region == 2'b11) && (int'(widx) < DW);
  assign din_wr     = acc_wr & din_hit;
  assign key_wr     = acc_wr & key_hit;
  assign start_ctrl = ctrl_wr & writedata[0];
  assign clr_req    = ctrl_wr & writedata[2];

`ifdef CIPHER_AUTO_START_EN
  assign auto_start = din_wr && (widx == 3'(DW - 1)) && byteenable[3];
`else
  assign auto_start = 1'b0;
`endif
  // A combined CTRL start and auto start still yields one go pulse.
  assign start_req  = start_ctrl | auto_start;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    state_d = state;
    go      = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: if (start_req) begin go = 1'b1; state_d = RUN; end
      RUN:  if (cnt == '0) begin cap = 1'b1; state_d = DONE; end
      DONE: begin
        if (start_req) begin go = 1'b1; state_d = RUN; end
        else if (clr_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (address == '0)                rd_mux = {30'b0, irq_en, 1'b0};
    else if (address == ADDR_W'(1))   rd_mux = {29'b0, err, state == DONE, busy};
    for (int i = 0; i < DW; i++) begin
      if (din_hit  && widx == 3'(i)) rd_mux = din[i];
      if (dout_hit && widx == 3'(i)) rd_mux = dout[i];
    end
    for (int i = 0; i < KW; i++)
      if (key_hit && widx == 3'(i)) rd_mux = key[i];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      core_start <= 1'b0;
      irq_en     <= 1'b0;
      err        <= 1'b0;
      readdata   <= '0;
      for (int i = 0; i < DW; i++) begin din[i] <= '0; dout[i] <= '0; end
      for (int i = 0; i < KW; i++) key[i] <= '0;
    end else begin
      state      <= state_d;
      core_start <= go;
      if (go)                        cnt <= CW'(CORE_LATENCY - 1);
      else if (busy && cnt != '0)    cnt <= cnt - 1'b1;
      if (ctrl_wr) irq_en <= writedata[1];
      if (busy && (start_ctrl || din_wr || key_wr)) err <= 1'b1;
      else if (clr_req && !busy)                    err <= 1'b0;
      if (acc_rd) readdata <= rd_mux;
      for (int i = 0; i < DW; i++) begin
        if (din_wr && !busy && widx == 3'(i)) din[i] <= merge(din[i], writedata, byteenable);
        if (cap) dout[i] <= core_data_out[DATA_BITS-1-32*i -: 32];
      end
      for (int i = 0; i < KW; i++)
        if (key_wr && !busy && widx == 3'(i)) key[i] <= merge(key[i], writedata, byteenable);
    end
  end

  // Word 0 is the most significant word on the core buses.
  for (genvar g = 0; g < DW; g++) begin : g_din
    assign core_data_in[DATA_BITS-1-32*g -: 32] = din[g];
  end
  for (genvar g = 0; g < KW; g++) begin : g_key
    assign core_key[KEY_BITS-1-32*g -: 32] = key[g];
  end

  assign done_export = (state == DONE);
  assign irq         = done_export & irq_en;
endmodule
